// File: rtl/pif_mem_slave.sv
// pif_mem_slave: parametrised PIF slave memory with in-order outstanding-request queue,
// block transfers, configurable read latency, address-error responses and ID/priority echo.
module pif_mem_slave #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                MEM_AW    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h6000_0000,
   parameter int                RD_LAT    = 2,
   parameter int                QDEPTH    = 4
) (
   input  logic                CLK,
   input  logic                BResetN,
   input  logic                POReqValid,
   output logic                PIReqRdy,
   input  logic [7:0]          POReqCntl,
   input  logic [ADDR_W-1:0]   POReqAdrs,
   input  logic [DATA_W-1:0]   POReqData,
   input  logic [DATA_W/8-1:0] POReqDataBE,
   input  logic [5:0]          POReqId,
   input  logic [1:0]          POReqPriority,
   output logic                PIRespValid,
   input  logic                PORespRdy,
   output logic [7:0]          PIRespCntl,
   output logic [DATA_W-1:0]   PIRespData,
   output logic [5:0]          PIRespId,
   output logic [1:0]          PIRespPriority
);
   localparam int WB = DATA_W / 8;
   localparam int BW = $clog2(WB);
   localparam int QW = $clog2(QDEPTH);
   localparam logic [ADDR_W:0] LIM = {1'b0, BASE_ADDR} + ({{ADDR_W{1'b0}}, 1'b1} << (MEM_AW + BW));

   typedef enum logic [1:0] {IDLE, WAIT, BEAT} st_t;
   typedef struct packed {
      logic              wr;
      logic              err;
      logic [3:0]        n1;
      logic [5:0]        id;
      logic [1:0]        pri;
      logic [ADDR_W-1:0] addr;
   } ent_t;

   logic [DATA_W-1:0] mem [2**MEM_AW];
   ent_t              q [QDEPTH];
   st_t               st_q, st_d;
   logic [QW-1:0]     rp_q, rp_d, wp_q, wp_d, rp_n;
   logic [QW:0]       cnt_q, cnt_d;
   logic [3:0]        lat_q, lat_d, beat_q, beat_d, lb, op;
   logic              wr_act_q, wr_act_d, wr_err_q, wr_err_d, werr;
   logic [ADDR_W-1:0] wr_adr_q, wr_adr_d, wa, ra, la, bsz;
   logic              rdy_q, rdy_d, vld_q, vld_d;
   logic [7:0]        cntl_q, cntl_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [5:0]        id_q, id_d;
   logic [1:0]        pri_q, pri_d;
   logic              acc, push, pop, sel, ld, last, mem_we, unused;
   ent_t              pe, head, se;

   function automatic logic in_rng(input logic [ADDR_W-1:0] a);
      return {1'b0, a} >= {1'b0, BASE_ADDR} && {1'b0, a} < LIM;
   endfunction

   assign op             = POReqCntl[7:4];
   assign PIReqRdy       = rdy_q;
   assign PIRespValid    = vld_q;
   assign PIRespCntl     = cntl_q;
   assign PIRespData     = data_q;
   assign PIRespId       = id_q;
   assign PIRespPriority = pri_q;
   assign unused         = ^{POReqCntl[3], la};

   always_comb begin
      rp_n     = rp_q + QW'(1);
      head     = q[rp_q];
      acc      = POReqValid & rdy_q & BResetN;
      wa       = wr_act_q ? wr_adr_q : POReqAdrs;
      bsz      = {{(ADDR_W-1){1'b0}}, 1'b1} << (BW + 1 + int'(POReqCntl[2:1]));
      ra       = (op == 4'h1) ? (POReqAdrs & ~(bsz - 1'b1)) : POReqAdrs;
      werr     = wr_err_q | !in_rng(wa);
      mem_we   = acc && (op == 4'h8 || op == 4'h9) && in_rng(wa);
      push     = 1'b0;
      pe       = '0;
      wr_act_d = wr_act_q;
      wr_err_d = wr_err_q;
      wr_adr_d = wr_adr_q;
      // block-write beats follow an internal address counter; the error flag accumulates over the block
      if (acc && (op == 4'h8 || op == 4'h9)) begin
         wr_act_d = !POReqCntl[0];
         wr_err_d = POReqCntl[0] ? 1'b0 : werr;
         wr_adr_d = wa + ADDR_W'(WB);
         push     = POReqCntl[0];
         pe.wr    = 1'b1;
         pe.err   = werr;
         pe.id    = POReqId;
         pe.pri   = POReqPriority;
         pe.addr  = wa;
      end else if (acc && (op == 4'h0 || op == 4'h1)) begin
         push     = 1'b1;
         pe.err   = !in_rng(ra);
         pe.n1    = (op == 4'h1 && in_rng(ra)) ? 4'((5'd2 << POReqCntl[2:1]) - 5'd1) : 4'd0;
         pe.id    = POReqId;
         pe.pri   = POReqPriority;
         pe.addr  = ra;
      end
      st_d   = st_q;
      lat_d  = lat_q;
      beat_d = beat_q;
      pop    = 1'b0;
      sel    = 1'b0;
      ld     = 1'b0;
      lb     = 4'd0;
      se     = head;
      last   = beat_q == head.n1;
      case (st_q)
         IDLE: sel = cnt_q != '0;
         WAIT: begin
            st_d  = (lat_q == 4'd0) ? BEAT : WAIT;
            ld    = lat_q == 4'd0;
            lat_d = lat_q - 4'd1;
         end
         BEAT: if (PORespRdy) begin
            ld     = !last;
            lb     = beat_q + 4'd1;
            beat_d = beat_q + 4'd1;
            pop    = last;
            sel    = last && cnt_q > (QW+1)'(1);
            se     = last ? q[rp_n] : head;
            st_d   = last ? IDLE : BEAT;
         end
         default: ;
      endcase
      // the next head is picked in the same cycle the previous one retires, so writes/errors stream back-to-back
      if (sel) begin
         beat_d = 4'd0;
         lb     = 4'd0;
         ld     = se.wr | se.err;
         st_d   = (se.wr | se.err) ? BEAT : WAIT;
         lat_d  = 4'(RD_LAT - 1);
      end
      la     = se.addr + (ADDR_W'(lb) << BW);
      vld_d  = ld ? 1'b1 : pop ? 1'b0 : vld_q;
      cntl_d = ld ? {se.err ? 4'h2 : se.wr ? 4'h1 : 4'h0, 3'b000, lb == se.n1} : pop ? 8'h00 : cntl_q;
      data_d = ld ? ((se.wr | se.err) ? '0 : mem[la[BW +: MEM_AW]]) : pop ? '0 : data_q;
      id_d   = ld ? se.id : pop ? 6'd0 : id_q;
      pri_d  = ld ? se.pri : pop ? 2'd0 : pri_q;
      cnt_d  = cnt_q + (QW+1)'(push) - (QW+1)'(pop);
      rp_d   = rp_q + QW'(pop);
      wp_d   = wp_q + QW'(push);
      rdy_d  = cnt_d < (QW+1)'(QDEPTH);
   end

   always_ff @(posedge CLK) begin
      if (!BResetN) begin
         st_q     <= IDLE;
         rp_q     <= '0;
         wp_q     <= '0;
         cnt_q    <= '0;
         lat_q    <= '0;
         beat_q   <= '0;
         wr_act_q <= 1'b0;
         wr_err_q <= 1'b0;
         wr_adr_q <= '0;
         rdy_q    <= 1'b0;
         vld_q    <= 1'b0;
         cntl_q   <= '0;
         data_q   <= '0;
         id_q     <= '0;
         pri_q    <= '0;
      end else begin
         st_q     <= st_d;
         rp_q     <= rp_d;
         wp_q     <= wp_d;
         cnt_q    <= cnt_d;
         lat_q    <= lat_d;
         beat_q   <= beat_d;
         wr_act_q <= wr_act_d;
         wr_err_q <= wr_err_d;
         wr_adr_q <= wr_adr_d;
         rdy_q    <= rdy_d;
         vld_q    <= vld_d;
         cntl_q   <= cntl_d;
         data_q   <= data_d;
         id_q     <= id_d;
         pri_q    <= pri_d;
      end
   end

   // memory and queue storage survive reset
   always_ff @(posedge CLK) begin
      if (mem_we)
         for (int i = 0; i < WB; i++)
            if (POReqDataBE[i]) mem[wa[BW +: MEM_AW]][i*8 +: 8] <= POReqData[i*8 +: 8];
      if (push) q[wp_q] <= pe;
   end
endmodule

// File: tb/tb_pif_mem_slave.sv
// tb_pif_mem_slave: directed bench for pif_mem_slave with default parameters
// (32-bit data, base 0x6000_0000, 64K words, RD_LAT=2, QDEPTH=4).
module tb_pif_mem_slave;
   logic        CLK = 1'b0, BResetN = 1'b0, POReqValid = 1'b0, PORespRdy = 1'b1;
   logic        PIReqRdy, PIRespValid;
   logic [7:0]  POReqCntl = '0, PIRespCntl;
   logic [31:0] POReqAdrs = '0, POReqData = '0, PIRespData;
   logic [3:0]  POReqDataBE = '0;
   logic [5:0]  POReqId = '0, PIRespId;
   logic [1:0]  POReqPriority = '0, PIRespPriority;
   int          checks = 0, failures = 0;
   logic [7:0]  rc;
   logic [31:0] rd;
   logic [5:0]  ri;
   logic [1:0]  rp;
   int          rn;

   pif_mem_slave dut (
      .CLK(CLK), .BResetN(BResetN), .POReqValid(POReqValid), .PIReqRdy(PIReqRdy),
      .POReqCntl(POReqCntl), .POReqAdrs(POReqAdrs), .POReqData(POReqData),
      .POReqDataBE(POReqDataBE), .POReqId(POReqId), .POReqPriority(POReqPriority),
      .PIRespValid(PIRespValid), .PORespRdy(PORespRdy), .PIRespCntl(PIRespCntl),
      .PIRespData(PIRespData), .PIRespId(PIRespId), .PIRespPriority(PIRespPriority)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [5:0] id, input logic [1:0] pr);
      logic ok = 1'b0;
      POReqValid = 1'b1; POReqCntl = c; POReqAdrs = a; POReqData = d;
      POReqDataBE = be; POReqId = id; POReqPriority = pr;
      for (int i = 0; i < 64 && !ok; i++) begin
         ok = PIReqRdy;
         @(posedge CLK); #1;
      end
      POReqValid = 1'b0;
      if (!ok) begin
         checks++; failures++;
         $display("FAIL send_timeout id=%0d got=not_accepted exp=accepted", id);
      end
   endtask

   task automatic get_resp(output logic [7:0] c, output logic [31:0] d, output logic [5:0] id,
                           output logic [1:0] pr, output int n);
      n = 0;
      while (PIRespValid !== 1'b1 && n < 64) begin
         @(posedge CLK); #1; n++;
      end
      if (PIRespValid !== 1'b1) begin
         checks++; failures++;
         $display("FAIL resp_timeout got=no_valid exp=valid");
      end
      c = PIRespCntl; d = PIRespData; id = PIRespId; pr = PIRespPriority;
      if (PORespRdy) begin @(posedge CLK); #1; end
   endtask

   task automatic test_reset;
      BResetN = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if ({PIReqRdy, PIRespValid, PIRespCntl, PIRespData, PIRespId, PIRespPriority} !== 50'd0) begin
         failures++; $display("FAIL reset_outputs got=%h exp=0",
            {PIReqRdy, PIRespValid, PIRespCntl, PIRespData, PIRespId, PIRespPriority});
      end
      BResetN = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if (PIReqRdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", PIReqRdy); end
   endtask

   task automatic test_single;
      send(8'h81, 32'h6000_0010, 32'hDEAD_BEEF, 4'hF, 6'd5, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if (rc !== 8'h11) begin failures++; $display("FAIL single_wr_cntl got=%h exp=11", rc); end
      checks++;
      if (ri !== 6'd5) begin failures++; $display("FAIL single_wr_id got=%0d exp=5", ri); end
      checks++;
      if (rd !== 32'd0) begin failures++; $display("FAIL single_wr_data got=%h exp=0", rd); end
      send(8'h00, 32'h6000_0010, 32'd0, 4'h0, 6'd6, 2'd2);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if (rn !== 3) begin failures++; $display("FAIL single_rd_latency got=%0d exp=3", rn); end
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rd_data got=%h exp=deadbeef", rd); end
      checks++;
      if (rc !== 8'h01) begin failures++; $display("FAIL single_rd_cntl got=%h exp=01", rc); end
      checks++;
      if ({ri, rp} !== {6'd6, 2'd2}) begin failures++; $display("FAIL single_rd_idpri got=%0d/%0d exp=6/2", ri, rp); end
   endtask

   task automatic test_byte_enable;
      send(8'h81, 32'h6000_0040, 32'hFFFF_FFFF, 4'hF, 6'd7, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      send(8'h81, 32'h6000_0040, 32'h1122_3344, 4'h5, 6'd8, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      send(8'h00, 32'h6000_0040, 32'd0, 4'h0, 6'd9, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if (rd !== 32'hFF22_FF44) begin failures++; $display("FAIL byte_enable got=%h exp=ff22ff44", rd); end
   endtask

   task automatic test_block_read;
      for (int i = 0; i < 4; i++) begin
         send(8'h81, 32'h6000_0020 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 4'hF, 6'(10 + i), 2'd1);
         get_resp(rc, rd, ri, rp, rn);
      end
      send(8'h12, 32'h6000_0024, 32'd0, 4'h0, 6'd20, 2'd3);
      for (int i = 0; i < 4; i++) begin
         get_resp(rc, rd, ri, rp, rn);
         checks++;
         if (rd !== 32'hA0A0_0000 + 32'(i)) begin
            failures++; $display("FAIL blkrd_data%0d got=%h exp=%h", i, rd, 32'hA0A0_0000 + 32'(i));
         end
         checks++;
         if (rc !== ((i == 3) ? 8'h01 : 8'h00)) begin failures++; $display("FAIL blkrd_cntl%0d got=%h", i, rc); end
      end
      checks++;
      if (ri !== 6'd20) begin failures++; $display("FAIL blkrd_id got=%0d exp=20", ri); end
   endtask

   task automatic test_block_write;
      for (int i = 0; i < 4; i++)
         send((i == 3) ? 8'h93 : 8'h92, (i == 0) ? 32'h6000_0100 : 32'hDEAD_0000,
              32'hB0B0_0000 + 32'(i), 4'hF, 6'd21, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if ({rc, ri} !== {8'h11, 6'd21}) begin failures++; $display("FAIL blkwr_resp got=%h/%0d exp=11/21", rc, ri); end
      send(8'h12, 32'h6000_010C, 32'd0, 4'h0, 6'd22, 2'd0);
      for (int i = 0; i < 4; i++) begin
         get_resp(rc, rd, ri, rp, rn);
         checks++;
         if (rd !== 32'hB0B0_0000 + 32'(i)) begin
            failures++; $display("FAIL blkwr_data%0d got=%h exp=%h", i, rd, 32'hB0B0_0000 + 32'(i));
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [5:0] ids [3];
      int cyc [3];
      int k = 0;
      for (int c = 0; c < 12; c++) begin
         if (PIRespValid === 1'b1 && k < 3) begin ids[k] = PIRespId; cyc[k] = c; k++; end
         POReqValid = (c < 3); POReqCntl = 8'h81; POReqAdrs = 32'h6000_0200 + 32'(4 * c);
         POReqData = 32'(c); POReqDataBE = 4'hF; POReqId = 6'(30 + c);
         @(posedge CLK); #1;
      end
      POReqValid = 1'b0;
      checks++;
      if (k !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", k); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ids[i] !== 6'(30 + i)) begin failures++; $display("FAIL b2b_id%0d got=%0d exp=%0d", i, ids[i], 30 + i); end
         end
         checks++;
         if (cyc[2] - cyc[0] !== 2) begin failures++; $display("FAIL b2b_bubbles got=%0d exp=2", cyc[2] - cyc[0]); end
      end
   endtask

   task automatic test_backpressure;
      logic [5:0] got [5];
      int k = 0, acc_c = -1, first_c = -1;
      PORespRdy = 1'b0;
      for (int i = 1; i <= 3; i++) send(8'h00, 32'h6000_0010, 32'd0, 4'h0, 6'(i), 2'd0);
      checks++;
      if (PIReqRdy !== 1'b1) begin failures++; $display("FAIL bp_rdy_after3 got=%b exp=1", PIReqRdy); end
      send(8'h00, 32'h6000_0010, 32'd0, 4'h0, 6'd4, 2'd0);
      checks++;
      if (PIReqRdy !== 1'b0) begin failures++; $display("FAIL bp_rdy_after4 got=%b exp=0", PIReqRdy); end
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if ({PIRespValid, PIRespId, PIRespCntl, PIRespData} !== {1'b1, 6'd1, 8'h01, 32'hDEAD_BEEF}) begin
         failures++; $display("FAIL bp_hold got=%b/%0d/%h/%h exp=1/1/01/deadbeef", PIRespValid, PIRespId, PIRespCntl, PIRespData);
      end
      POReqValid = 1'b1; POReqCntl = 8'h00; POReqAdrs = 32'h6000_0010; POReqId = 6'd5;
      PORespRdy = 1'b1;
      for (int c = 0; c < 80 && k < 5; c++) begin
         if (PIRespValid === 1'b1) begin got[k] = PIRespId; if (k == 0) first_c = c; k++; end
         if (POReqValid && PIReqRdy === 1'b1) acc_c = c;
         @(posedge CLK); #1;
         if (acc_c >= 0) POReqValid = 1'b0;
      end
      POReqValid = 1'b0;
      checks++;
      if (k !== 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", k); end
      else for (int i = 0; i < 5; i++) begin
         checks++;
         if (got[i] !== 6'(i + 1)) begin failures++; $display("FAIL bp_order%0d got=%0d exp=%0d", i, got[i], i + 1); end
      end
      checks++;
      if (acc_c !== first_c + 1) begin failures++; $display("FAIL bp_accept_cycle got=%0d exp=%0d", acc_c, first_c + 1); end
   endtask

   task automatic test_error;
      int v = 0;
      send(8'h00, 32'h1000_0000, 32'd0, 4'h0, 6'd40, 2'd1);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if ({rc, rd, ri, rp} !== {8'h21, 32'd0, 6'd40, 2'd1}) begin
         failures++; $display("FAIL err_rd got=%h/%h/%0d/%0d exp=21/0/40/1", rc, rd, ri, rp);
      end
      send(8'h14, 32'h1000_0000, 32'd0, 4'h0, 6'd41, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      for (int c = 0; c < 6; c++) begin
         if (PIRespValid === 1'b1) v++;
         @(posedge CLK); #1;
      end
      checks++;
      if ({rc, ri} !== {8'h21, 6'd41}) begin failures++; $display("FAIL err_blk got=%h/%0d exp=21/41", rc, ri); end
      checks++;
      if (v !== 0) begin failures++; $display("FAIL err_blk_single got=%0d extra beats exp=0", v); end
      send(8'h81, 32'h6000_0000, 32'h1234_5678, 4'hF, 6'd42, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      send(8'h81, 32'h6004_0000, 32'hCAFE_F00D, 4'hF, 6'd43, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if (rc !== 8'h21) begin failures++; $display("FAIL err_wr_high got=%h exp=21", rc); end
      send(8'h81, 32'h5FFF_FFFC, 32'hCAFE_F00D, 4'hF, 6'd44, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if (rc !== 8'h21) begin failures++; $display("FAIL err_wr_low got=%h exp=21", rc); end
      send(8'h81, 32'h6003_FFFC, 32'h0BAD_CAFE, 4'hF, 6'd45, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if (rc !== 8'h11) begin failures++; $display("FAIL err_wr_top got=%h exp=11", rc); end
      send(8'h00, 32'h6000_0000, 32'd0, 4'h0, 6'd46, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if (rd !== 32'h1234_5678) begin failures++; $display("FAIL err_mem_kept got=%h exp=12345678", rd); end
      send(8'h00, 32'h6003_FFFC, 32'd0, 4'h0, 6'd47, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if (rd !== 32'h0BAD_CAFE) begin failures++; $display("FAIL err_top_word got=%h exp=0badcafe", rd); end
   endtask

   task automatic test_reset_mid;
      int v = 0;
      send(8'h14, 32'h6000_0000, 32'd0, 4'h0, 6'd50, 2'd2);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if ({rc, rd} !== {8'h00, 32'h1234_5678}) begin failures++; $display("FAIL rstmid_beat0 got=%h/%h exp=00/12345678", rc, rd); end
      BResetN = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if ({PIReqRdy, PIRespValid, PIRespCntl, PIRespData, PIRespId, PIRespPriority} !== 50'd0) begin
         failures++; $display("FAIL rstmid_outputs got=%h exp=0",
            {PIReqRdy, PIRespValid, PIRespCntl, PIRespData, PIRespId, PIRespPriority});
      end
      BResetN = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if (PIReqRdy !== 1'b1) begin failures++; $display("FAIL rstmid_rdy got=%b exp=1", PIReqRdy); end
      for (int c = 0; c < 12; c++) begin
         if (PIRespValid !== 1'b0) v++;
         @(posedge CLK); #1;
      end
      checks++;
      if (v !== 0) begin failures++; $display("FAIL rstmid_stale got=%0d beats exp=0", v); end
      send(8'h00, 32'h6000_0000, 32'd0, 4'h0, 6'd51, 2'd0);
      get_resp(rc, rd, ri, rp, rn);
      checks++;
      if ({rd, ri} !== {32'h1234_5678, 6'd51}) begin failures++; $display("FAIL rstmid_after got=%h/%0d exp=12345678/51", rd, ri); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_byte_enable;
      test_block_read;
      test_block_write;
      test_back_to_back;
      test_backpressure;
      test_error;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
